spi_slave_rx: RTL and testbench

SPI Mode 0 slave receiver (CPOL=0, CPHA=0), MSB-first, 8-bit words. This is the receiving end for the team's SPI master.
- Samples the external SCLK/CS/MOSI pins in the local clk domain and deserialises bytes.
- Presents each byte through a one-entry valid/ready holding register.
- Flags overrun and framing errors.
- Feeds the logic-analyzer capture and display command path.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_slave_rx_if.sv | 42 ++++
 rtl/spi_sync.sv | 28 ++
 rtl/spi_slave_rx.sv | 192 +++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave receiver and the team's SPI master.
//   SPI_DATA_W  : default word width
//   CPOL/CPHA   : SPI mode 0 (clock idles low, sample on rising edge)
//   spi_state_e : slave framing states
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Consumer-side bus of the SPI slave receiver.
//   slave  modport : seen by spi_slave_rx (drives data/status, takes rx_ready/ovr_clr)
//   master modport : seen by the consumer of received bytes
//   rx_data/rx_valid/rx_ready : one-entry valid/ready holding register
//   overrun/ovr_clr           : sticky drop flag and its clear
//   frame_err                 : one-cycle pulse, CS rose mid-byte
//   busy                      : chip select (synchronised) asserted
interface spi_slave_rx_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              overrun;
    logic              ovr_clr;
    logic              frame_err;
    logic              busy;

    modport slave (
        output rx_data,
        output rx_valid,
        output overrun,
        output frame_err,
        output busy,
        input  rx_ready,
        input  ovr_clr
    );

    modport master (
        input  rx_data,
        input  rx_valid,
        input  overrun,
        input  frame_err,
        input  busy,
        output rx_ready,
        output ovr_clr
    );

endinterface

// File: rtl/spi_sync.sv
// N-stage synchroniser for one asynchronous pin.
//   clk, rst : local clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronised output, N clk cycles of latency
//   RST_VAL  : value loaded into every stage on reset
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {N{RST_VAL}};
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode 0 slave receiver, MSB first, DATA_W-bit words.
// Pins are synchronised into clk, bytes are deserialised on synced SCLK
// rises and handed over through a one-entry valid/ready holding register.
//
// Ports:
//   clk, rst        : system clock, async active-high reset
//   sclk_in         : SPI clock pin (idles low)
//   cs_in           : chip select pin, active low
//   mosi_in         : serial data in
//   rx_bus (slave)  : rx_data/rx_valid/rx_ready, overrun/ovr_clr, frame_err, busy
//   miso, tx_data   : only when SPI_SLAVE_TX_EN is defined (full duplex)
//
// Build option: define SPI_SLAVE_TX_EN to add the transmit shifter.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | CS deasserted (or not yet re-armed); counter and shifter cleared
// ACTIVE | CS asserted; shift on each SCLK rise, multi-byte frames allowed
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = SPI_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk_in,
    input  logic               cs_in,
    input  logic               mosi_in,
`ifdef SPI_SLAVE_TX_EN
    output logic               miso,
    input  logic [DATA_W-1:0]  tx_data,
`endif
    spi_slave_rx_if.slave      rx_bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_d;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .rst (rst), .d (sclk_in), .q (sclk_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk), .rst (rst), .d (cs_in), .q (cs_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .rst (rst), .d (mosi_in), .q (mosi_s)
    );

    spi_state_e        state;
    spi_state_e        state_nxt;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] byte_word;
    logic              rise;
    logic              rx_rise;
    logic              byte_done;

    // After reset the CS synchroniser shows its reset value, not the pin.
    // flush_pipe tracks when the synchronised CS reflects real pin samples,
    // so a CS held low across reset cannot open a frame mid-byte.
    logic [SYNC_STAGES-1:0] flush_pipe;
    logic                   armed;

    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              overrun_q;
    logic              busy_c;
    logic              frame_err_c;

    assign rise      = sclk_s & ~sclk_d;
    assign rx_rise   = (state == ACTIVE) & ~cs_s & rise;
    assign byte_done = rx_rise & (bit_cnt == LAST_BIT);
    assign byte_word = {shift[DATA_W-2:0], mosi_s};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cs_s && armed) state_nxt = ACTIVE;
            ACTIVE:  if (cs_s)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_c      = (state == ACTIVE);
        frame_err_c = (state == ACTIVE) && cs_s && (bit_cnt != '0);
    end

    // ---------------- pin history, arming ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d     <= 1'b0;
            flush_pipe <= '0;
            armed      <= 1'b0;
        end else begin
            sclk_d     <= sclk_s;
            flush_pipe <= {flush_pipe[SYNC_STAGES-2:0], 1'b1};
            if (flush_pipe[SYNC_STAGES-1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // ---------------- receive shifter ----------------
    // Leaving ACTIVE (or sitting in IDLE) discards any partial byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (state != ACTIVE || cs_s) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (rise) begin
            shift   <= byte_word;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // ---------------- holding register ----------------
    // A completing byte may replace the held one only when the consumer
    // takes the held one in that same cycle; otherwise it is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (byte_done && (!rx_valid_q || rx_bus.rx_ready)) begin
                rx_data_q  <= byte_word;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (byte_done && rx_valid_q && !rx_bus.rx_ready) begin
                overrun_q <= 1'b1;
            end else if (rx_bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data   = rx_data_q;
    assign rx_bus.rx_valid  = rx_valid_q;
    assign rx_bus.overrun   = overrun_q;
    assign rx_bus.frame_err = frame_err_c;
    assign rx_bus.busy      = busy_c;

`ifdef SPI_SLAVE_TX_EN
    // ---------------- transmit shifter ----------------
    // The fall following the last rise of a byte sees bit_cnt already
    // wrapped to zero; that fall reloads the next word instead of shifting.
    logic [DATA_W-1:0] tx_shift;
    logic              fall;

    assign fall = ~sclk_s & sclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
        end else if (state == IDLE && state_nxt == ACTIVE) begin
            tx_shift <= tx_data;
        end else if (state == ACTIVE && !cs_s && fall) begin
            if (bit_cnt == '0) begin
                tx_shift <= tx_data;
            end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign miso = (state == ACTIVE) ? tx_shift[DATA_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed plus randomised bench for spi_slave_rx. Expected bytes come from
// a byte-level model: every completed byte is queued as expected when the
// consumer is ready; with the consumer stalled only the first byte is held.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int H    = 5;   // SCLK half period in clk cycles
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk_in = 1'b0;
    logic cs_in = 1'b1;
    logic mosi_in = 1'b0;
`ifdef SPI_SLAVE_TX_EN
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] miso_sh = 8'h00;
`endif

    spi_slave_rx_if #(.DATA_W(8)) bus ();

    spi_slave_rx #(.SYNC_STAGES(SYNC), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk_in (sclk_in),
        .cs_in   (cs_in),
        .mosi_in (mosi_in),
`ifdef SPI_SLAVE_TX_EN
        .miso    (miso),
        .tx_data (tx_data),
`endif
        .rx_bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Handshake inputs change just after posedge, so at negedge both sides
    // of the handshake hold the values the next posedge will use.
    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
        if (bus.frame_err) fe_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rx(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // mode 0: plain bit; 1: pulse rx_ready on the completion cycle;
    // 2: pulse ovr_clr on the completion cycle.
    task automatic spi_bit(input logic b, input int mode);
        mosi_in = b;
        step(H);
`ifdef SPI_SLAVE_TX_EN
        miso_sh = {miso_sh[6:0], miso};
`endif
        sclk_in = 1'b1;
        if (mode != 0) begin
            step(SYNC);
            if (mode == 1) bus.rx_ready = 1'b1;
            else           bus.ovr_clr  = 1'b1;
            step(1);
            bus.rx_ready = 1'b0;
            bus.ovr_clr  = 1'b0;
            step(H - SYNC - 1);
        end else begin
            step(H);
        end
        sclk_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int last_mode);
        for (int i = 7; i >= 1; i--) spi_bit(b[i], 0);
        spi_bit(b[0], last_mode);
    endtask

    task automatic cs_low();
        cs_in = 1'b0;
        step(H + SYNC);
    endtask

    task automatic cs_high();
        step(H);
        cs_in = 1'b1;
        step(H + SYNC + 3);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] first_b;
        int         n;
        int         k;
        int         fe_exp;

        bus.rx_ready = 1'b0;
        bus.ovr_clr  = 1'b0;

        // reset values
        step(3);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_overrun", bus.overrun, 1'b0);
        chk("rst_frame_err", bus.frame_err, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
`ifdef SPI_SLAVE_TX_EN
        chk("rst_miso", miso, 1'b0);
`endif
        rst = 1'b0;
        step(SYNC + 3);

        // 1: single byte 0xA5 with latency check on the last bit
        bus.rx_ready = 1'b1;
        b = 8'hA5;
        cs_low();
        for (int i = 7; i >= 1; i--) spi_bit(b[i], 0);
        mosi_in = b[0];
        step(H);
        sclk_in = 1'b1;
        step(SYNC);
        chk("t1_valid_before_latency", bus.rx_valid, 1'b0);
        step(1);
        chk("t1_valid_at_latency", bus.rx_valid, 1'b1);
        chk("t1_data_at_latency", bus.rx_data, 8'hA5);
        step(H - SYNC - 1);
        sclk_in = 1'b0;
        exp_q.push_back(8'hA5);
        cs_high();
        chk_rx("t1_rx");
        chk("t1_frame_err", fe_cnt, 0);
        chk("t1_overrun", bus.overrun, 1'b0);
        chk("t1_valid_cleared", bus.rx_valid, 1'b0);

        // 2: two bytes in one frame, busy held
        cs_low();
        chk("t2_busy_start", bus.busy, 1'b1);
        send_byte(8'h3C, 0);
        chk("t2_busy_mid", bus.busy, 1'b1);
        send_byte(8'hC3, 0);
        step(2);
        chk("t2_busy_end", bus.busy, 1'b1);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        cs_high();
        chk("t2_busy_idle", bus.busy, 1'b0);
        chk_rx("t2_rx");

        // 3: CS raised after 5 bits, then a clean byte
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 0);
        cs_high();
        chk("t3_frame_err_pulses", fe_cnt, 1);
        chk_rx("t3_partial_rx");
        cs_low();
        send_byte(8'h81, 0);
        exp_q.push_back(8'h81);
        cs_high();
        chk_rx("t3_rx");
        chk("t3_frame_err_after", fe_cnt, 1);

        // 4: stalled consumer, overrun, clear, set-wins
        bus.rx_ready = 1'b0;
        cs_low();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        cs_high();
        chk("t4_valid", bus.rx_valid, 1'b1);
        chk("t4_data", bus.rx_data, 8'h11);
        chk("t4_overrun", bus.overrun, 1'b1);
        bus.ovr_clr = 1'b1;
        step(1);
        bus.ovr_clr = 1'b0;
        chk("t4_overrun_cleared", bus.overrun, 1'b0);
        chk("t4_data_kept", bus.rx_data, 8'h11);
        cs_low();
        send_byte(8'h44, 2);
        cs_high();
        chk("t4_set_wins", bus.overrun, 1'b1);
        chk("t4_data_kept2", bus.rx_data, 8'h11);
        bus.ovr_clr = 1'b1;
        step(1);
        bus.ovr_clr = 1'b0;
        bus.rx_ready = 1'b1;
        step(1);
        chk("t4_valid_after_accept", bus.rx_valid, 1'b0);
        chk("t4_overrun_final", bus.overrun, 1'b0);
        exp_q.push_back(8'h11);
        chk_rx("t4_rx");

        // 5: reset mid-byte, CS still low after reset must not capture
        fe_exp = fe_cnt;
        cs_low();
        spi_bit(1'b1, 0);
        spi_bit(1'b0, 0);
        spi_bit(1'b1, 0);
        spi_bit(1'b0, 0);
        rst = 1'b1;
        step(2);
        chk("t5_rst_data", bus.rx_data, 8'h00);
        chk("t5_rst_valid", bus.rx_valid, 1'b0);
        chk("t5_rst_overrun", bus.overrun, 1'b0);
        chk("t5_rst_busy", bus.busy, 1'b0);
        chk("t5_rst_frame_err", bus.frame_err, 1'b0);
        rst = 1'b0;
        step(SYNC + 2);
        send_byte(8'hFF, 0);
        chk("t5_not_armed_busy", bus.busy, 1'b0);
        chk("t5_not_armed_valid", bus.rx_valid, 1'b0);
        cs_high();
        chk_rx("t5_not_armed_rx");
        cs_low();
        send_byte(8'h5A, 0);
        exp_q.push_back(8'h5A);
        cs_high();
        chk_rx("t5_rx");
        chk("t5_no_frame_err", fe_cnt, fe_exp);
        bus.rx_ready = 1'b0;
        cs_low();
        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        chk("t5_b2b_overrun", bus.overrun, 1'b0);
        chk("t5_b2b_data", bus.rx_data, 8'h34);
        chk("t5_b2b_valid", bus.rx_valid, 1'b1);
        cs_high();
        bus.rx_ready = 1'b1;
        step(1);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        chk_rx("t5_b2b_rx");

        // random frames with a ready consumer, interleaved with partial frames
        fe_exp = fe_cnt;
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 3);
            cs_low();
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                send_byte(b, 0);
            end
            cs_high();
            k = $urandom_range(1, 7);
            cs_low();
            for (int j = 0; j < k; j++) spi_bit(1'($urandom), 0);
            cs_high();
            fe_exp++;
        end
        chk_rx("rnd_rx");
        chk("rnd_frame_err", fe_cnt, fe_exp);

        // random burst into a stalled consumer
        bus.rx_ready = 1'b0;
        n = $urandom_range(2, 4);
        first_b = 8'($urandom);
        cs_low();
        send_byte(first_b, 0);
        for (int j = 1; j < n; j++) send_byte(8'($urandom), 0);
        cs_high();
        chk("rnd_ovr_data", bus.rx_data, first_b);
        chk("rnd_ovr_flag", bus.overrun, 1'b1);
        bus.ovr_clr = 1'b1;
        bus.rx_ready = 1'b1;
        step(1);
        bus.ovr_clr = 1'b0;
        exp_q.push_back(first_b);
        chk("rnd_ovr_cleared", bus.overrun, 1'b0);
        chk_rx("rnd_ovr_rx");

`ifdef SPI_SLAVE_TX_EN
        // 6: full duplex
        tx_data = 8'h96;
        chk("t6_miso_idle", miso, 1'b0);
        cs_low();
        send_byte(8'h0F, 0);
        exp_q.push_back(8'h0F);
        cs_high();
        chk("t6_miso_word", miso_sh, 8'h96);
        chk("t6_miso_idle_after", miso, 1'b0);
        chk_rx("t6_rx");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
